// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port synchronous-read memory between the
// instruction-fetch requester (F) and the load/store requester (D).
// At most one access is granted per cycle; read data is returned to the
// owning requester one cycle after its grant. D normally wins contention,
// but after MAX_DATA_BURST consecutive D grants with F waiting, F is served.
module mem_arbiter #(
    parameter int AW             = 8,
    parameter int DW             = 8,
    parameter int MAX_DATA_BURST = 4   // legal range 1..15
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          f_req,
    input  logic [AW-1:0] f_addr,
    output logic          f_gnt,
    output logic          f_rvalid,
    output logic [DW-1:0] f_rdata,

    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,

    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    // State records which requester (if any) was granted in the previous cycle.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAST_F = 2'd1,
        LAST_D = 2'd2
    } state_e;

    localparam logic [3:0] BURST_MAX = 4'(MAX_DATA_BURST);

    state_e        state_q, state_d;
    logic [3:0]    burst_cnt_q, burst_cnt_d;
    logic          d_read_q, d_read_d;    // last D grant was a read
    logic [AW-1:0] addr_q, addr_d;        // last granted address, held while idle

    // Grant arbitration, memory drive and next-state computation.
    always_comb begin
        // NOTE: every signal gets a default before any branch so no latch can be inferred.
        f_gnt       = 1'b0;
        d_gnt       = 1'b0;
        state_d     = IDLE;
        burst_cnt_d = burst_cnt_q;
        d_read_d    = 1'b0;

        // No grants at all while reset is asserted.
        if (!rst) begin
            if (f_req && (!d_req || burst_cnt_q == BURST_MAX)) begin
                f_gnt = 1'b1;
            end else if (d_req) begin
                d_gnt = 1'b1;
            end
        end

        mem_we    = d_gnt & d_we;
        mem_wdata = d_wdata;              // don't-care unless mem_we is high
        mem_addr  = addr_q;
        if (f_gnt) begin
            mem_addr = f_addr;
        end else if (d_gnt) begin
            mem_addr = d_addr;
        end
        addr_d = mem_addr;

        if (f_gnt) begin
            state_d = LAST_F;
        end else if (d_gnt) begin
            state_d  = LAST_D;
            d_read_d = ~d_we;
        end

        // Count D grants taken while F is waiting; saturate so F wins next.
        if (f_gnt || !f_req) begin
            burst_cnt_d = 4'd0;
        end else if (d_gnt && burst_cnt_q != BURST_MAX) begin
            burst_cnt_d = burst_cnt_q + 4'd1;
        end
    end

    // State, burst counter and held address registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            burst_cnt_q <= 4'd0;
            d_read_q    <= 1'b0;
            addr_q      <= '0;
        end else begin
            // NOTE: non-blocking assignments keep all registers updating from pre-edge values.
            state_q     <= state_d;
            burst_cnt_q <= burst_cnt_d;
            d_read_q    <= d_read_d;
            addr_q      <= addr_d;
        end
    end

    // Read responses follow directly from the registered last-grant state.
    assign f_rvalid = (state_q == LAST_F);
    assign d_rvalid = (state_q == LAST_D) && d_read_q;
    assign f_rdata  = mem_rdata;
    assign d_rdata  = mem_rdata;

endmodule
